stdp_weight_update_arbiter: RTL and testbench

Shared weight-update controller for the spiking-column learning path. It holds NSYN saturating up/down synaptic weight counters with the same pulse semantics as the team's binary pulse counter. It round-robin arbitrates increment/decrement requests from NREQ learning requesters (STDP rule units) onto a single update port. At most one weight changes per clock, so concurrent requesters never collide on a counter.

---
 rtl/stdp_weight_update_arbiter.sv | 112 +++++++++++
 tb/tb_stdp_weight_update_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stdp_weight_update_arbiter.sv
// Round-robin arbiter that funnels STDP inc/dec requests onto NSYN saturating weight counters.
// Optional macro STDP_WUA_INIT_MID_EN: reset weights to mid-scale 2^(WBITS-1) instead of zero.
module stdp_weight_update_arbiter #(
  parameter int NREQ  = 4,
  parameter int NSYN  = 8,
  parameter int WBITS = 3,
  parameter int IDXW  = $clog2(NSYN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       inc,
  input  logic [NREQ-1:0]       dec,
  input  logic [NREQ*IDXW-1:0]  idx,
  output logic [NREQ-1:0]       gnt,
  output logic [NSYN*WBITS-1:0] weights,
  output logic                  sat_evt,
  output logic [IDXW-1:0]       upd_idx
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WBITS-1:0] W_MAX = {WBITS{1'b1}};
`ifdef STDP_WUA_INIT_MID_EN
  localparam logic [WBITS-1:0] W_INIT = WBITS'(1) << (WBITS - 1);
`else
  localparam logic [WBITS-1:0] W_INIT = '0;
`endif
  localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);

  // Saturating single step; both or neither qualifier leaves the weight untouched.
  function automatic logic [WBITS-1:0] step_weight(input logic [WBITS-1:0] cur,
                                                   input logic up, input logic dn);
    if (up && !dn && (cur != W_MAX)) return cur + WBITS'(1);
    if (dn && !up && (cur != '0))    return cur - WBITS'(1);
    return cur;
  endfunction

  function automatic logic is_sat(input logic [WBITS-1:0] cur,
                                  input logic up, input logic dn);
    return (up && !dn && (cur == W_MAX)) || (dn && !up && (cur == '0));
  endfunction

  logic [WBITS-1:0] wgt_p0 [NSYN];
  logic [PW-1:0]    ptr_p0;

  logic [NREQ-1:0]  elig;
  logic             vld_p0;
  logic [PW-1:0]    win;
  logic [NREQ-1:0]  win_oh;
  logic [IDXW-1:0]  win_idx;
  logic             win_inc;
  logic             win_dec;
  logic [WBITS-1:0] win_cur;

  assign elig = req & ~gnt;

  // Stage p0: two-pass search (above ptr first, then wrap) gives round-robin order.
  always_comb begin
    vld_p0  = 1'b0;
    win     = ptr_p0;
    win_oh  = '0;
    win_idx = '0;
    win_inc = 1'b0;
    win_dec = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      if (!vld_p0 && elig[r] && (PW'(r) > ptr_p0)) begin
        vld_p0 = 1'b1;
        win    = PW'(r);
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (!vld_p0 && elig[r] && (PW'(r) <= ptr_p0)) begin
        vld_p0 = 1'b1;
        win    = PW'(r);
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      if (vld_p0 && (PW'(r) == win)) begin
        win_oh[r] = 1'b1;
        win_idx   = idx[r*IDXW +: IDXW];
        win_inc   = inc[r];
        win_dec   = dec[r];
      end
    end
  end

  assign win_cur = wgt_p0[win_idx];

  // Stage p0 -> outputs: weight write, grant, saturation flag and pointer share one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSYN; s++) wgt_p0[s] <= W_INIT;
      gnt     <= '0;
      sat_evt <= 1'b0;
      upd_idx <= '0;
      ptr_p0  <= PTR_INIT;
    end else begin
      gnt     <= win_oh;
      sat_evt <= vld_p0 && is_sat(win_cur, win_inc, win_dec);
      if (vld_p0) begin
        wgt_p0[win_idx] <= step_weight(win_cur, win_inc, win_dec);
        upd_idx         <= win_idx;
        ptr_p0          <= win;
      end
    end
  end

  for (genvar s = 0; s < NSYN; s++) begin : g_flat
    assign weights[s*WBITS +: WBITS] = wgt_p0[s];
  end

endmodule

// File: tb/tb_stdp_weight_update_arbiter.sv
// Directed bench for stdp_weight_update_arbiter (NREQ=4, NSYN=8, WBITS=3).
module tb_stdp_weight_update_arbiter;
  localparam int NREQ  = 4;
  localparam int NSYN  = 8;
  localparam int WBITS = 3;
  localparam int IDXW  = 3;
`ifdef STDP_WUA_INIT_MID_EN
  localparam int W_INIT = 4;
`else
  localparam int W_INIT = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       inc;
  logic [NREQ-1:0]       dec;
  logic [NREQ*IDXW-1:0]  idx;
  logic [NREQ-1:0]       gnt;
  logic [NSYN*WBITS-1:0] weights;
  logic                  sat_evt;
  logic [IDXW-1:0]       upd_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stdp_weight_update_arbiter #(.NREQ(NREQ), .NSYN(NSYN), .WBITS(WBITS)) dut (
    .clk(clk), .rst(rst), .req(req), .inc(inc), .dec(dec), .idx(idx),
    .gnt(gnt), .weights(weights), .sat_evt(sat_evt), .upd_idx(upd_idx)
  );

  function automatic int wt(input int s);
    return int'(weights[s*WBITS +: WBITS]);
  endfunction

  task automatic clear_inputs();
    req = '0; inc = '0; dec = '0; idx = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (sat_evt !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", sat_evt); end
    total++; if (upd_idx !== 3'd0) begin bad++; $display("FAIL reset_upd_idx got=%0d want=0", upd_idx); end
    for (int s = 0; s < NSYN; s++) begin
      total++;
      if (wt(s) !== W_INIT) begin bad++; $display("FAIL reset_w%0d got=%0d want=%0d", s, wt(s), W_INIT); end
    end
  endtask

  task automatic test_inc_saturate();
    int ew;
    logic [3:0] eg;
    logic es;
    ew = W_INIT;
    apply_reset();
    req = 4'b0001; inc = 4'b0001; idx[2:0] = 3'd3;
    for (int c = 1; c <= 16; c++) begin
      cycle();
      eg = 4'b0000; es = 1'b0;
      if (c % 2 == 1) begin
        eg = 4'b0001;
        if (ew == 7) es = 1'b1; else ew++;
      end
      total++; if (gnt !== eg) begin bad++; $display("FAIL inc_gnt c=%0d got=%b want=%b", c, gnt, eg); end
      total++; if (wt(3) !== ew) begin bad++; $display("FAIL inc_w3 c=%0d got=%0d want=%0d", c, wt(3), ew); end
      total++; if (sat_evt !== es) begin bad++; $display("FAIL inc_sat c=%0d got=%b want=%b", c, sat_evt, es); end
    end
    total++; if (upd_idx !== 3'd3) begin bad++; $display("FAIL inc_upd_idx got=%0d want=3", upd_idx); end
    clear_inputs();
  endtask

  task automatic test_dec_floor();
    int ew;
    logic es;
    ew = (W_INIT == 0) ? 0 : W_INIT - 1;
    es = (W_INIT == 0);
    apply_reset();
    req = 4'b0100; dec = 4'b0100; idx[8:6] = 3'd5;
    cycle();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL dec_gnt got=%b want=0100", gnt); end
    total++; if (wt(5) !== ew) begin bad++; $display("FAIL dec_w5 got=%0d want=%0d", wt(5), ew); end
    total++; if (sat_evt !== es) begin bad++; $display("FAIL dec_sat got=%b want=%b", sat_evt, es); end
    total++; if (upd_idx !== 3'd5) begin bad++; $display("FAIL dec_upd_idx got=%0d want=5", upd_idx); end
    clear_inputs();
    cycle();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL dec_gnt_drop got=%b want=0000", gnt); end
    total++; if (sat_evt !== 1'b0) begin bad++; $display("FAIL dec_sat_drop got=%b want=0", sat_evt); end
  endtask

  task automatic test_round_robin();
    int cnt [NREQ];
    int w;
    int ew;
    logic [3:0] eg;
    for (int r = 0; r < NREQ; r++) cnt[r] = 0;
    apply_reset();
    req = 4'b1111; inc = 4'b1111;
    idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 8; c++) begin
      cycle();
      w = c % 4;
      eg = 4'b0001 << w;
      cnt[w]++;
      ew = (W_INIT + cnt[w] > 7) ? 7 : W_INIT + cnt[w];
      total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, eg); end
      total++; if (wt(w) !== ew) begin bad++; $display("FAIL rr_w%0d c=%0d got=%0d want=%0d", w, c, wt(w), ew); end
      total++; if (upd_idx !== 3'(w)) begin bad++; $display("FAIL rr_upd_idx c=%0d got=%0d want=%0d", c, upd_idx, w); end
    end
    clear_inputs();
  endtask

  task automatic test_same_synapse();
    int ew;
    ew = W_INIT;
    apply_reset();
    req = 4'b0001; inc = 4'b0001; idx[2:0] = 3'd6;
    for (int c = 1; c <= 3; c++) begin
      cycle();
      if (c % 2 == 1 && ew < 7) ew++;
    end
    total++; if (wt(6) !== ew) begin bad++; $display("FAIL same_pre_w6 got=%0d want=%0d", wt(6), ew); end
    clear_inputs();
    cycle();
    req = 4'b1010; inc = 4'b1010; idx[5:3] = 3'd6; idx[11:9] = 3'd6;
    cycle();
    if (ew < 7) ew++;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL same_gnt1 got=%b want=0010", gnt); end
    total++; if (wt(6) !== ew) begin bad++; $display("FAIL same_w6_1 got=%0d want=%0d", wt(6), ew); end
    cycle();
    if (ew < 7) ew++;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL same_gnt3 got=%b want=1000", gnt); end
    total++; if (wt(6) !== ew) begin bad++; $display("FAIL same_w6_3 got=%0d want=%0d", wt(6), ew); end
    clear_inputs();
    cycle();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL same_gnt_end got=%b want=0000", gnt); end
    total++; if (wt(6) !== ew) begin bad++; $display("FAIL same_w6_end got=%0d want=%0d", wt(6), ew); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req = 4'b0001; inc = 4'b0001; dec = 4'b0001; idx[2:0] = 3'd2;
    cycle();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL both_gnt got=%b want=0001", gnt); end
    total++; if (wt(2) !== W_INIT) begin bad++; $display("FAIL both_w2 got=%0d want=%0d", wt(2), W_INIT); end
    total++; if (sat_evt !== 1'b0) begin bad++; $display("FAIL both_sat got=%b want=0", sat_evt); end
    total++; if (upd_idx !== 3'd2) begin bad++; $display("FAIL both_upd_idx got=%0d want=2", upd_idx); end
    req = 4'b0101; inc = 4'b0101; idx[8:6] = 3'd1;
    cycle();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL mask_gnt got=%b want=0100", gnt); end
    total++; if (wt(1) !== W_INIT + 1) begin bad++; $display("FAIL mask_w1 got=%0d want=%0d", wt(1), W_INIT + 1); end
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_mid_gnt got=%b want=0000", gnt); end
    total++; if (wt(1) !== W_INIT) begin bad++; $display("FAIL rst_mid_w1 got=%0d want=%0d", wt(1), W_INIT); end
    total++; if (upd_idx !== 3'd0) begin bad++; $display("FAIL rst_mid_upd_idx got=%0d want=0", upd_idx); end
    total++; if (sat_evt !== 1'b0) begin bad++; $display("FAIL rst_mid_sat got=%b want=0", sat_evt); end
    @(negedge clk);
    rst = 1'b0;
    cycle();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL post_rst_gnt got=%b want=0001", gnt); end
    total++; if (wt(2) !== W_INIT) begin bad++; $display("FAIL post_rst_w2 got=%0d want=%0d", wt(2), W_INIT); end
    clear_inputs();
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_inc_saturate();
    test_dec_floor();
    test_round_robin();
    test_same_synapse();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
